// File: rtl/misao_alu_seq_pkg.sv
// misao_alu_pkg: shared types and helpers for the digit-serial MISA-O ALU.
//   alu_op_t     - ALU operation codes (10..15 are reserved)
//   state_t      - sequencer states
//   calc_ndig    - digit count for a given width / digit width
//   calc_len_w   - width of the active-length field
//   op_reserved  - true for the reserved op codes
package misao_alu_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DIGIT_W = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_XOR = 4'd2,
    ALU_INV = 4'd3,
    ALU_SHL = 4'd4,
    ALU_SHR = 4'd5,
    ALU_ADD = 4'd6,
    ALU_SUB = 4'd7,
    ALU_INC = 4'd8,
    ALU_DEC = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit_w);
    return width / digit_w;
  endfunction

  function automatic int calc_len_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  function automatic logic op_reserved(input logic [3:0] op);
    return op > 4'd9;
  endfunction

  localparam int DEF_NDIG  = calc_ndig(DEF_WIDTH, DEF_DIGIT_W);
  localparam int DEF_LEN_W = calc_len_w(DEF_NDIG);

endpackage

// File: rtl/misao_alu_seq_if.sv
// misao_alu_seq_if: request/response bundle between the execute FSM and the
// digit-serial ALU.
//   request : in_valid, in_ready, op_i, len_i, a_i, b_i
//   response: out_valid, out_ready, result_o, carry_o, zero_o, illegal_o
//   master  - requester (execute FSM / testbench)
//   slave   - the ALU
interface misao_alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_i;
  logic [LEN_W-1:0] len_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             zero_o;
  logic             illegal_o;

  modport master (
    output in_valid, op_i, len_i, a_i, b_i, out_ready,
    input  in_ready, out_valid, result_o, carry_o, zero_o, illegal_o
  );

  modport slave (
    input  in_valid, op_i, len_i, a_i, b_i, out_ready,
    output in_ready, out_valid, result_o, carry_o, zero_o, illegal_o
  );
endinterface

// File: rtl/misao_alu_seq_digit.sv
// misao_alu_digit: combinational one-digit ALU slice.
//   op    - ALU op code (reserved codes pass a through)
//   a, b  - operand digits
//   cin   - carry / borrow / shift bit from the previously processed digit
//   first - this is the first digit of the op: replaces cin with the seed
//           (0 for ADD/SUB/shift fill, 1 for INC/DEC)
//   y     - result digit
//   cout  - carry / borrow / shifted-out bit towards the next digit
module misao_alu_digit
  import misao_alu_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [3:0]         op,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  logic               first,
  output logic [DIGIT_W-1:0] y,
  output logic               cout
);

  logic             cfill;  // chained bit, 0 on the first digit
  logic             cseed;  // chained bit, 1 on the first digit (INC/DEC)
  logic [DIGIT_W:0] ext;

  always_comb begin
    cfill = first ? 1'b0 : cin;
    cseed = first ? 1'b1 : cin;
    ext   = '0;
    y     = a;
    cout  = 1'b0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_INV: y = ~a;
      ALU_SHL: begin
        y    = {a[DIGIT_W-2:0], cfill};
        cout = a[DIGIT_W-1];
      end
      ALU_SHR: begin
        y    = {cfill, a[DIGIT_W-1:1]};
        cout = a[0];
      end
      ALU_ADD: begin
        ext  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cfill};
        y    = ext[DIGIT_W-1:0];
        cout = ext[DIGIT_W];
      end
      ALU_SUB: begin
        // top bit of the extended difference is the borrow
        ext  = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, cfill};
        y    = ext[DIGIT_W-1:0];
        cout = ext[DIGIT_W];
      end
      ALU_INC: begin
        ext  = {1'b0, a} + {{DIGIT_W{1'b0}}, cseed};
        y    = ext[DIGIT_W-1:0];
        cout = ext[DIGIT_W];
      end
      ALU_DEC: begin
        ext  = {1'b0, a} - {{DIGIT_W{1'b0}}, cseed};
        y    = ext[DIGIT_W-1:0];
        cout = ext[DIGIT_W];
      end
      default: begin
        y    = a;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/misao_alu_seq.sv
// misao_alu_seq: digit-serial ALU for the MISA-O core. Processes one
// DIGIT_W-bit slice of the active width per clock, chaining carry/shift bits
// between slices through a single misao_alu_digit instance.
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - misao_alu_seq_if.slave (request / response handshake)
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// RUN   | one digit per clock, len+1 clocks
// DONE  | out_valid=1, result held until out_ready
module misao_alu_seq
  import misao_alu_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DIGIT_W = DEF_DIGIT_W,
  localparam int NDIG    = calc_ndig(WIDTH, DIGIT_W),
  localparam int LEN_W   = calc_len_w(NDIG)
) (
  input logic             clk,
  input logic             rst,
  misao_alu_seq_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;

  logic [3:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [WIDTH-1:0] res_q;     // starts as a_i, digits overwritten in place
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             zero_q;
  logic             illegal_q;

  logic             accept;
  logic             first_dig;
  logic             last_dig;
  logic [LEN_W-1:0] len_clamp;
  int               base;
  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic [DIGIT_W-1:0] dig_y;
  logic             dig_cout;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.result_o  = res_q;
  assign bus.carry_o   = carry_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    len_clamp = bus.len_i;
    if (32'(bus.len_i) > 32'(NDIG - 1)) begin
      len_clamp = LEN_W'(NDIG - 1);
    end
  end

  // SHR walks from the top active digit down so the fill bit enters at the top.
  always_comb begin
    first_dig = 1'b0;
    last_dig  = 1'b0;
    if (op_q == ALU_SHR) begin
      first_dig = (idx_q == len_q);
      last_dig  = (idx_q == '0);
    end else begin
      first_dig = (idx_q == '0);
      last_dig  = (idx_q == len_q);
    end
  end

  always_comb begin
    base  = int'(idx_q) * DIGIT_W;
    dig_a = res_q[base +: DIGIT_W];
    dig_b = b_q[base +: DIGIT_W];
  end

  misao_alu_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .op    (op_q),
    .a     (dig_a),
    .b     (dig_b),
    .cin   (carry_q),
    .first (first_dig),
    .y     (dig_y),
    .cout  (dig_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last_dig)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= bus.op_i;
        len_q     <= len_clamp;
        idx_q     <= (bus.op_i == ALU_SHR) ? len_clamp : '0;
        res_q     <= bus.a_i;
        b_q       <= bus.b_i;
        carry_q   <= 1'b0;
        zero_q    <= 1'b1;
        illegal_q <= op_reserved(bus.op_i);
      end else if (state == RUN) begin
        res_q[base +: DIGIT_W] <= dig_y;
        carry_q <= dig_cout;
        zero_q  <= zero_q && (dig_y == '0);
        if (!last_dig) begin
          idx_q <= (op_q == ALU_SHR) ? idx_q - 1'b1 : idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_misao_alu_seq.sv
module tb_misao_alu_seq;
  import misao_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  misao_alu_seq_if #(.WIDTH(16), .LEN_W(2)) bus ();

  misao_alu_seq #(.WIDTH(16), .DIGIT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive one request from IDLE; scramble the inputs after acceptance and
  // count edges until out_valid (-1 if it never arrives).
  task automatic run_op(input logic [3:0] op, input logic [1:0] len,
                        input logic [15:0] a, input logic [15:0] b,
                        output int edges);
    bus.op_i = op; bus.len_i = len; bus.a_i = a; bus.b_i = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_i = op ^ 4'h3; bus.len_i = ~len; bus.a_i = ~a; bus.b_i = 16'h5A5A;
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus.out_valid) edges = -1;
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_i = '0; bus.len_i = '0; bus.a_i = '0; bus.b_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.result_o !== 16'h0000) begin errors++; $display("FAIL rst_result: got %h exp 0000", bus.result_o); end
    checks++; if ({bus.carry_o, bus.zero_o, bus.illegal_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {bus.carry_o, bus.zero_o, bus.illegal_o}); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_add();
    int e;
    run_op(ALU_ADD, 2'd3, 16'hFFFF, 16'h0001, e);
    checks++; if (e !== 4) begin errors++; $display("FAIL add_latency: got %0d exp 4", e); end
    checks++; if (bus.result_o !== 16'h0000) begin errors++; $display("FAIL add_result: got %h exp 0000", bus.result_o); end
    checks++; if (bus.carry_o !== 1'b1) begin errors++; $display("FAIL add_carry: got %b exp 1", bus.carry_o); end
    checks++; if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL add_zero: got %b exp 1", bus.zero_o); end
    checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b exp 0", bus.illegal_o); end
    release_op();
  endtask

  task automatic test_sub();
    int e;
    run_op(ALU_SUB, 2'd0, 16'h1232, 16'h0003, e);
    checks++; if (e !== 1) begin errors++; $display("FAIL sub_latency: got %0d exp 1", e); end
    checks++; if (bus.result_o !== 16'h123F) begin errors++; $display("FAIL sub_result: got %h exp 123f", bus.result_o); end
    checks++; if (bus.carry_o !== 1'b1) begin errors++; $display("FAIL sub_borrow: got %b exp 1", bus.carry_o); end
    checks++; if (bus.zero_o !== 1'b0) begin errors++; $display("FAIL sub_zero: got %b exp 0", bus.zero_o); end
    release_op();
  endtask

  task automatic test_shift();
    int e;
    run_op(ALU_SHR, 2'd1, 16'hA581, 16'hFFFF, e);
    checks++; if (e !== 2) begin errors++; $display("FAIL shr_latency: got %0d exp 2", e); end
    checks++; if (bus.result_o !== 16'hA540) begin errors++; $display("FAIL shr_result: got %h exp a540", bus.result_o); end
    checks++; if (bus.carry_o !== 1'b1) begin errors++; $display("FAIL shr_carry: got %b exp 1", bus.carry_o); end
    release_op();
    run_op(ALU_SHL, 2'd2, 16'h0080, 16'h0000, e);
    checks++; if (bus.result_o !== 16'h0100) begin errors++; $display("FAIL shl3_result: got %h exp 0100", bus.result_o); end
    checks++; if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL shl3_carry: got %b exp 0", bus.carry_o); end
    release_op();
    // bit 7 is the top active bit of a one-byte op, so it leaves as carry
    run_op(ALU_SHL, 2'd1, 16'h0080, 16'h0000, e);
    checks++; if (bus.result_o !== 16'h0000) begin errors++; $display("FAIL shl2_result: got %h exp 0000", bus.result_o); end
    checks++; if ({bus.carry_o, bus.zero_o} !== 2'b11) begin errors++; $display("FAIL shl2_flags: got %b exp 11", {bus.carry_o, bus.zero_o}); end
    release_op();
  endtask

  task automatic test_inc_dec();
    int e;
    run_op(ALU_INC, 2'd1, 16'h12FF, 16'hFFFF, e);
    checks++; if (bus.result_o !== 16'h1200) begin errors++; $display("FAIL inc_result: got %h exp 1200", bus.result_o); end
    checks++; if ({bus.carry_o, bus.zero_o} !== 2'b11) begin errors++; $display("FAIL inc_flags: got %b exp 11", {bus.carry_o, bus.zero_o}); end
    release_op();
    run_op(ALU_DEC, 2'd3, 16'h0000, 16'h1111, e);
    checks++; if (bus.result_o !== 16'hFFFF) begin errors++; $display("FAIL dec_wrap_result: got %h exp ffff", bus.result_o); end
    checks++; if ({bus.carry_o, bus.zero_o} !== 2'b10) begin errors++; $display("FAIL dec_wrap_flags: got %b exp 10", {bus.carry_o, bus.zero_o}); end
    release_op();
    run_op(ALU_DEC, 2'd1, 16'h1234, 16'h0000, e);
    checks++; if (bus.result_o !== 16'h1233) begin errors++; $display("FAIL dec_result: got %h exp 1233", bus.result_o); end
    checks++; if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL dec_borrow: got %b exp 0", bus.carry_o); end
    release_op();
  endtask

  task automatic test_logic_chain();
    logic [3:0]  ops [4];
    logic [15:0] bs  [4];
    logic [15:0] exp_r [4];
    logic [15:0] acc;
    int e;
    ops[0] = ALU_AND; bs[0] = 16'h000F; exp_r[0] = 16'h0003;
    ops[1] = ALU_INV; bs[1] = 16'h0000; exp_r[1] = 16'h000C;
    ops[2] = ALU_OR;  bs[2] = 16'h0003; exp_r[2] = 16'h000F;
    ops[3] = ALU_XOR; bs[3] = 16'h000C; exp_r[3] = 16'h0003;
    acc = 16'h0003;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) begin
        run_op(ops[k], 2'd0, acc, bs[k], e);
        checks++; if (bus.result_o !== exp_r[k]) begin errors++; $display("FAIL logic_result[%0d.%0d]: got %h exp %h", pass, k, bus.result_o, exp_r[k]); end
        checks++; if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL logic_carry[%0d.%0d]: got %b exp 0", pass, k, bus.carry_o); end
        acc = exp_r[k];
        release_op();
      end
    end
  endtask

  task automatic test_back_pressure();
    int e;
    run_op(ALU_ADD, 2'd1, 16'h1234, 16'h0F0F, e);
    bus.op_i = ALU_INV; bus.len_i = 2'd0; bus.a_i = 16'h0000; bus.b_i = 16'h0000;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", c, bus.out_valid); end
      checks++; if ({bus.result_o, bus.carry_o, bus.zero_o} !== {16'h1243, 2'b00}) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b%b exp 1243/00", c, bus.result_o, bus.carry_o, bus.zero_o); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", c, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    release_op();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b exp 1", bus.in_ready); end
    run_op(ALU_SUB, 2'd3, 16'h0005, 16'h0007, e);
    checks++; if (e !== 4) begin errors++; $display("FAIL bp_next_latency: got %0d exp 4", e); end
    checks++; if ({bus.result_o, bus.carry_o} !== {16'hFFFE, 1'b1}) begin errors++; $display("FAIL bp_next_result: got %h/%b exp fffe/1", bus.result_o, bus.carry_o); end
    release_op();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    bus.op_i = ALU_ADD; bus.len_i = 2'd3; bus.a_i = 16'hFFFF; bus.b_i = 16'h0001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b exp 0", bus.out_valid); end
    checks++; if ({bus.result_o, bus.carry_o, bus.zero_o, bus.illegal_o} !== 19'h0) begin errors++; $display("FAIL mid_rst_outputs: got %h/%b%b%b exp 0000/000", bus.result_o, bus.carry_o, bus.zero_o, bus.illegal_o); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0", bus.in_ready); end
    rst = 1'b0;
    seen = 0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_after: got %b exp 1", bus.in_ready); end
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_valid: got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_illegal();
    int e;
    run_op(4'd12, 2'd3, 16'hBEEF, 16'h1234, e);
    checks++; if (e !== 4) begin errors++; $display("FAIL ill_latency: got %0d exp 4", e); end
    checks++; if (bus.result_o !== 16'hBEEF) begin errors++; $display("FAIL ill_result: got %h exp beef", bus.result_o); end
    checks++; if ({bus.illegal_o, bus.carry_o, bus.zero_o} !== 3'b100) begin errors++; $display("FAIL ill_flags: got %b exp 100", {bus.illegal_o, bus.carry_o, bus.zero_o}); end
    release_op();
    run_op(ALU_AND, 2'd0, 16'h00F0, 16'h000F, e);
    checks++; if (bus.result_o !== 16'h00F0) begin errors++; $display("FAIL and_upper_result: got %h exp 00f0", bus.result_o); end
    checks++; if ({bus.illegal_o, bus.zero_o} !== 2'b01) begin errors++; $display("FAIL and_upper_flags: got %b exp 01", {bus.illegal_o, bus.zero_o}); end
    release_op();
  endtask

  task automatic test_back_to_back();
    int acc_cnt;
    int val_cnt;
    int wait_cnt;
    acc_cnt = 0; val_cnt = 0;
    bus.out_ready = 1'b1;
    bus.op_i = ALU_ADD; bus.len_i = 2'd0; bus.a_i = 16'h0001; bus.b_i = 16'h0001;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.in_ready) acc_cnt++;
      if (bus.out_valid) val_cnt++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d exp 4", acc_cnt); end
    checks++; if (val_cnt !== 4) begin errors++; $display("FAIL b2b_results: got %0d exp 4", val_cnt); end
    checks++; if (bus.result_o !== 16'h0002) begin errors++; $display("FAIL b2b_result: got %h exp 0002", bus.result_o); end
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b exp 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_inc_dec();
    test_logic_chain();
    test_back_pressure();
    test_reset_mid_run();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
